// File: rtl/shift_left_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// shift_left_sequencer: parallel-to-serial controller that owns an external
// shift-left register. Revision: 1.0
// ------------------------------------------------------------------------
module shift_left_sequencer #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic [CNT_W-1:0] s_cnt,
  output logic             s_ready,
  input  logic             abort,
  output logic             sr_load_en,
  output logic             sr_shift_en,
  output logic [WIDTH-1:0] sr_d_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [CNT_W-1:0]   c_width_cnt = CNT_W'(WIDTH);
  localparam int                 c_gap_w     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_gap_w-1:0] c_gap_load  = (GAP_CYCLES > 0) ? c_gap_w'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [c_gap_w-1:0] gap_q;
  logic [WIDTH-1:0]   d_in_q;
  logic               ready_q;
  logic               load_q;
  logic               shift_q;
  logic               done_q;
  logic               aborted_q;
  logic               accept;
  logic               sr_q_unused;

  // A zero or oversized count means a full-word transfer.
  assign cnt_d  = (s_cnt == '0 || s_cnt > c_width_cnt) ? c_width_cnt : s_cnt;
  // An abort on the same edge as a handshake suppresses the accept.
  assign accept = s_valid && ready_q && !abort;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      d_in_q    <= '0;
      ready_q   <= 1'b0;
      load_q    <= 1'b0;
      shift_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q   <= IDLE;
        load_q    <= 1'b0;
        shift_q   <= 1'b0;
        ready_q   <= 1'b1;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            ready_q <= 1'b1;
            if (accept) begin
              d_in_q  <= s_data;
              cnt_q   <= cnt_d;
              load_q  <= 1'b1;
              ready_q <= 1'b0;
              state_q <= LOAD;
            end
          end
          LOAD: begin
            load_q  <= 1'b0;
            shift_q <= 1'b1;
            state_q <= SHIFT;
          end
          SHIFT: begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              shift_q <= 1'b0;
              done_q  <= 1'b1;
              if (GAP_CYCLES > 0) begin
                gap_q   <= c_gap_load;
                state_q <= GAP;
              end else begin
                ready_q <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          GAP: begin
            if (gap_q == '0) begin
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              gap_q <= gap_q - c_gap_w'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign s_ready     = ready_q;
  assign sr_load_en  = load_q;
  assign sr_shift_en = shift_q;
  assign sr_d_in     = d_in_q;
  assign ser_valid   = shift_q;
  assign ser_out     = shift_q & sr_q[WIDTH-1];
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign aborted     = aborted_q;

  // Only the register MSB is observed; the rest is owned by the register.
  assign sr_q_unused = ^sr_q[WIDTH-2:0];

endmodule
`default_nettype wire

// File: tb/tb_shift_left_sequencer.sv
`default_nettype none
// Bench for shift_left_sequencer: models the shift register and scoreboards
// expected serial bits and completion events against the DUT.
module tb_shift_left_sequencer;

  localparam int WIDTH      = 8;
  localparam int CNT_W      = 4;
  localparam int GAP_CYCLES = 1;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             abort   = 1'b0;
  logic [WIDTH-1:0] s_data  = '0;
  logic [CNT_W-1:0] s_cnt   = '0;
  logic [WIDTH-1:0] sr_q    = '0;
  logic             s_ready, sr_load_en, sr_shift_en, ser_out, ser_valid;
  logic             busy, done, aborted;
  logic [WIDTH-1:0] sr_d_in;

  typedef struct {
    logic [1:0] k;   // 2'b10 done, 2'b01 aborted
    longint     t;
  } ev_t;

  logic   bitq[$];
  ev_t    evq[$];
  int     n_checks = 0;
  int     n_err    = 0;
  logic   rst_ok   = 1'b0;
  longint acc_t    = 0;
  logic   exp_b;
  ev_t    ev;

  shift_left_sequencer #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data),
    .s_cnt(s_cnt), .s_ready(s_ready), .abort(abort),
    .sr_load_en(sr_load_en), .sr_shift_en(sr_shift_en), .sr_d_in(sr_d_in),
    .sr_q(sr_q), .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy),
    .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Shift-left register owned by the DUT
  always @(posedge clk) begin
    if (sr_load_en)       sr_q <= sr_d_in;
    else if (sr_shift_en) sr_q <= {sr_q[WIDTH-2:0], 1'b0};
  end

  always @(posedge clk) rst_ok <= reset_n;

  always @(negedge clk) begin
    if (rst_ok) begin
      chk("load_shift_excl", sr_load_en & sr_shift_en, 0);
      chk("valid_eq_shift", ser_valid, sr_shift_en);
      chk("busy_eq_nready", busy, !s_ready);
    end
    if (ser_valid === 1'b1) begin
      if (bitq.size() == 0) chk("extra_bit", 1, 0);
      else begin
        exp_b = bitq.pop_front();
        chk("ser_out", ser_out, exp_b);
      end
    end
    if (done === 1'b1 || aborted === 1'b1) begin
      if (evq.size() == 0) chk("extra_event", {done, aborted}, 0);
      else begin
        ev = evq.pop_front();
        chk("event_kind", {done, aborted}, ev.k);
        chk("event_time", $time, ev.t);
      end
    end
  end

  task automatic chk_reset();
    chk("rst_load", sr_load_en, 0);
    chk("rst_shift", sr_shift_en, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_d_in", sr_d_in, 0);
  endtask

  // Offer a word; push its expected bits (and done if ev set) at the accept edge.
  task automatic send(input logic [7:0] d, input logic [3:0] c, input int nbits,
                      input bit want_done, input bit hold);
    int n;
    int t;
    n = (c == 0 || c > 8) ? 8 : int'(c);
    s_valid = 1'b1;
    s_data  = d;
    s_cnt   = c;
    t = 0;
    while (s_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (s_ready !== 1'b1) begin
      chk("accept_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    for (int i = 0; i < nbits; i++) bitq.push_back(d[7-i]);
    acc_t = $time + 5;
    if (want_done) evq.push_back('{k: 2'b10, t: acc_t + (n + 1) * 10 + 5});
    @(negedge clk);
    if (!hold) s_valid = 1'b0;
    s_data = ~d;
    s_cnt  = c + 4'd3;
  endtask

  task automatic wait_ready(input string tag, input int n);
    int t;
    t = 0;
    while (s_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, $time - acc_t, (2 + n + GAP_CYCLES) * 10 - 5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t1;
    int     t;
    repeat (2) @(negedge clk);
    chk_reset();
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_init", s_ready, 1);

    send(8'hA5, 4'd0, 8, 1'b1, 1'b0);
    wait_ready("ready_ret_a5", 8);

    send(8'hC3, 4'd3, 3, 1'b1, 1'b0);
    wait_ready("ready_ret_c3_3", 3);
    send(8'hC3, 4'd9, 8, 1'b1, 1'b0);
    wait_ready("ready_ret_c3_9", 8);

    send(8'hFF, 4'd0, 8, 1'b1, 1'b1);
    t1 = acc_t;
    send(8'h01, 4'd0, 8, 1'b1, 1'b0);
    chk("b2b_period", acc_t - t1, (2 + 8 + GAP_CYCLES) * 10);
    wait_ready("ready_ret_b2b", 8);

    // Abort on the 4th SHIFT cycle: four bits then an aborted pulse.
    send(8'hA5, 4'd0, 4, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    evq.push_back('{k: 2'b01, t: acc_t + 55});
    @(negedge clk);
    abort = 1'b0;
    chk("ready_after_abort", s_ready, 1);
    send(8'h3C, 4'd5, 5, 1'b1, 1'b0);
    wait_ready("ready_ret_3c", 5);

    // Reset during SHIFT after three bits.
    send(8'h96, 4'd0, 3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset();
    @(negedge clk);
    chk_reset();
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", s_ready, 1);
    send(8'h5A, 4'd0, 8, 1'b1, 1'b0);
    wait_ready("ready_ret_5a", 8);

    t = 0;
    while ((bitq.size() != 0 || evq.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("bits_left", bitq.size(), 0);
    chk("events_left", evq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
